bird_motion: RTL
================

BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of display rows; row 0 is the top row, ROWS-1 is the bottom row.
REQ-002 SHALL have parameter START_ROW, default 7, bird row after reset.
REQ-003 SHALL have parameter RISE_STEPS, default 2, number of upward ticks per flap.
REQ-004 SHALL have port clk  input  1  clock; all state changes on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flap  input  1  registered button level from the upstream flap-input stage.
REQ-007 SHALL have port tick  input  1  one-cycle game-step enable pulse.
REQ-008 SHALL have port collide  input  1  pipe-collision level from the obstacle logic.
REQ-009 SHALL have port row  output  $clog2(ROWS)  current bird row.
REQ-010 SHALL have port active  output  1  high in RISE or FALL.
REQ-011 SHALL have port dead  output  1  high in DEAD.

Function
REQ-012 SHALL implement FSM states IDLE, RISE, FALL and DEAD, plus rise counter rise_cnt (0..RISE_STEPS), pending-flap flag and flap_prev register.
REQ-013 SHALL register flap into flap_prev every cycle, and SHALL define flap_edge = flap & ~flap_prev; a held level SHALL yield exactly one edge.
REQ-014 SHALL set pending on flap_edge outside IDLE, and SHALL define eff_flap = pending | flap_edge at a tick; pending SHALL clear on every tick.
REQ-015 SHALL, in IDLE on flap_edge, go to RISE next cycle with rise_cnt=RISE_STEPS and pending=0; row SHALL be unchanged and tick SHALL be ignored in IDLE.
REQ-016 SHALL, on tick in RISE, set row = max(row-1, 0), so row 0 clamps and does not kill.
REQ-017 SHALL, on a RISE tick with eff_flap, reload rise_cnt=RISE_STEPS and stay in RISE; otherwise rise_cnt SHALL decrement, with a transition to FALL when it reaches 0.
REQ-018 SHALL, on tick in FALL with eff_flap, go to RISE with rise_cnt=RISE_STEPS and row-1 (clamped at 0) in that same tick.
REQ-019 SHALL, on tick in FALL without eff_flap, go to DEAD with row held if row==ROWS-1, else set row+1.
REQ-020 SHALL, on collide=1 in RISE or FALL, go to DEAD next cycle; collide SHALL take priority over a same-cycle tick and flap, and row SHALL NOT update that cycle.
REQ-021 SHALL, in DEAD, hold row, ignore flap/tick/collide, and exit only via reset.
REQ-022 SHALL generate row/active/dead directly from registers, with no combinational path from inputs.
REQ-023 SHALL NOT change row or state between ticks, except for the IDLE->RISE and ->DEAD (collide) transitions.

Reset
REQ-024 SHALL, on reset, set state=IDLE, row=START_ROW, rise_cnt=0, pending=0, flap_prev=0, active=0, dead=0.
REQ-025 SHALL give reset priority over all inputs, and mid-game reset SHALL return to REQ-024 values on the next edge.

Verification
REQ-026 SHALL be verified by: reset, then 4 ticks with flap=0 -> row=7, active=0, dead=0 throughout.
REQ-027 SHALL be verified by: flap 0->1 in IDLE, then 3 ticks -> active=1 next cycle; row 6, 5 (enter FALL), 6.
REQ-028 SHALL be verified by: flap held high across 5 ticks after start -> only one flap counted; rows 6, 5, 6, 7, 8.
REQ-029 SHALL be verified by: FALL at row 14 with ticks and no flap -> row 15, then dead=1 with row=15; further flaps/ticks -> no change.
REQ-030 SHALL be verified by: RISE at row 0 with a tick -> row stays 0, dead=0.
REQ-031 SHALL be verified by: collide=1 same cycle as tick and flap_edge in FALL at row 9 -> dead=1 next cycle, row=9; then reset -> row=7, dead=0.

Source files
------------

// File: rtl/bird_motion.sv
// Vertical motion controller for the bird: edge-detected flaps drive a short rise,
// otherwise the bird falls one row per game tick until it hits the floor or a pipe.
module bird_motion #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned START_ROW  = 7,
  parameter int unsigned RISE_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap,
  input  logic                    tick,
  input  logic                    collide,
  output logic [$clog2(ROWS)-1:0] row,
  output logic                    active,
  output logic                    dead
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(RISE_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_rise_cnt;
  logic          r_pending;
  logic          r_flap_prev;
  logic          r_active;
  logic          r_dead;

  logic          w_flap_edge;
  logic          w_eff_flap;
  logic [RW-1:0] w_row_up;
  logic          w_at_floor;

  assign w_flap_edge = flap & ~r_flap_prev;
  assign w_eff_flap  = r_pending | w_flap_edge;
  // Moving up saturates at the top row rather than killing the bird.
  assign w_row_up    = (r_row == '0) ? '0 : r_row - RW'(1);
  assign w_at_floor  = (r_row == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_row       <= RW'(START_ROW);
      r_rise_cnt  <= '0;
      r_pending   <= 1'b0;
      r_flap_prev <= 1'b0;
      r_active    <= 1'b0;
      r_dead      <= 1'b0;
    end else begin
      r_flap_prev <= flap;
      case (r_state)
        IDLE: begin
          if (w_flap_edge) begin
            r_state    <= RISE;
            r_rise_cnt <= CW'(RISE_STEPS);
            r_pending  <= 1'b0;
            r_active   <= 1'b1;
          end
        end
        RISE, FALL: begin
          // Collision wins over any same-cycle tick or flap and freezes the row.
          if (collide) begin
            r_state   <= DEAD;
            r_pending <= 1'b0;
            r_active  <= 1'b0;
            r_dead    <= 1'b1;
          end else if (tick) begin
            r_pending <= 1'b0;
            if (r_state == RISE) begin
              r_row <= w_row_up;
              if (w_eff_flap) begin
                r_rise_cnt <= CW'(RISE_STEPS);
              end else if (r_rise_cnt <= CW'(1)) begin
                r_rise_cnt <= '0;
                r_state    <= FALL;
              end else begin
                r_rise_cnt <= r_rise_cnt - CW'(1);
              end
            end else if (w_eff_flap) begin
              r_state    <= RISE;
              r_rise_cnt <= CW'(RISE_STEPS);
              r_row      <= w_row_up;
            end else if (w_at_floor) begin
              r_state  <= DEAD;
              r_active <= 1'b0;
              r_dead   <= 1'b1;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end else if (w_flap_edge) begin
            r_pending <= 1'b1;
          end
        end
        DEAD: begin
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign row    = r_row;
  assign active = r_active;
  assign dead   = r_dead;

endmodule
